// File: rtl/pe_pingpong_ctrl.sv
// pe_pingpong_ctrl: ping-pong controller around the PE operand buffer.
// One bank fills from the upstream stream while the other drains to the PE
// through a 2-entry output FIFO that absorbs the buffer's registered read.
// Optional feature: define PE_PINGPONG_FLUSH_EN to add a synchronous flush port.
`ifndef DATA_NUM
`define DATA_NUM 4
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

module pe_pingpong_ctrl #(
  parameter int DATA_NUM   = `DATA_NUM,
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int DEPTH      = 2 * DATA_NUM,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
`ifdef PE_PINGPONG_FLUSH_EN
  input  logic                  flush,
`endif
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  buf_write_en,
  output logic [ADDR_WIDTH-1:0] buf_write_addr,
  output logic [DATA_WIDTH-1:0] buf_data_in,
  output logic                  buf_read_en,
  output logic [ADDR_WIDTH-1:0] buf_read_addr,
  input  logic [DATA_WIDTH-1:0] buf_data_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic [1:0]            bank_full
);

  localparam int IDX_W = (DATA_NUM > 1) ? $clog2(DATA_NUM) : 1;
  localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(DATA_NUM - 1);
  localparam logic [ADDR_WIDTH-1:0] BANK1_BASE = ADDR_WIDTH'(DATA_NUM);

  logic flush_now;
`ifdef PE_PINGPONG_FLUSH_EN
  assign flush_now = flush;
`else
  assign flush_now = 1'b0;
`endif

  logic             w_bank_reg;
  logic [IDX_W-1:0] w_idx_reg;
  logic             r_bank_reg;
  logic [IDX_W-1:0] r_idx_reg;
  logic             rd_pend_reg;
  logic             rd_last_reg;
  logic [1:0]       bank_full_vec;
  logic             fifo_wr_ptr_reg;
  logic             fifo_rd_ptr_reg;
  logic [1:0]       fifo_cnt_reg;
  logic [DATA_WIDTH-1:0] fifo_data [2];
  logic                  fifo_last [2];

  logic       wr_fire;
  logic       wr_wrap;
  logic       rd_issue;
  logic       rd_wrap;
  logic       pop;
  logic [2:0] rd_occ;

  // Write side: accept whenever the bank being filled is not still full.
  assign in_ready       = !bank_full_vec[w_bank_reg] && !flush_now;
  assign wr_fire        = in_valid && in_ready;
  assign wr_wrap        = (w_idx_reg == IDX_LAST);
  assign buf_write_en   = wr_fire;
  assign buf_write_addr = (w_bank_reg ? BANK1_BASE : '0) + ADDR_WIDTH'(w_idx_reg);
  assign buf_data_in    = in_data;

  // Read side: only issue if the word can land in the FIFO without overflow,
  // counting the read already in flight and the word leaving this cycle.
  assign out_valid     = (fifo_cnt_reg != 2'd0);
  assign pop           = out_valid && out_ready;
  assign rd_occ        = 3'(fifo_cnt_reg) + 3'(rd_pend_reg) - 3'(pop);
  assign rd_issue      = bank_full_vec[r_bank_reg] && (rd_occ < 3'd2) && !flush_now;
  assign rd_wrap       = (r_idx_reg == IDX_LAST);
  assign buf_read_en   = rd_issue;
  assign buf_read_addr = (r_bank_reg ? BANK1_BASE : '0) + ADDR_WIDTH'(r_idx_reg);

  assign out_data  = fifo_data[fifo_rd_ptr_reg];
  assign out_last  = out_valid && fifo_last[fifo_rd_ptr_reg];
  assign bank_full = bank_full_vec;

  // Write pointer: advance per accepted word, swap banks after the last slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_bank_reg <= 1'b0;
      w_idx_reg  <= '0;
    end else if (flush_now) begin
      w_bank_reg <= 1'b0;
      w_idx_reg  <= '0;
    end else if (wr_fire) begin
      if (wr_wrap) begin
        w_idx_reg  <= '0;
        w_bank_reg <= ~w_bank_reg;
      end else begin
        w_idx_reg <= w_idx_reg + 1'b1;
      end
    end
  end

  // Read pointer and in-flight tracking for the one-cycle buffer latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bank_reg  <= 1'b0;
      r_idx_reg   <= '0;
      rd_pend_reg <= 1'b0;
      rd_last_reg <= 1'b0;
    end else if (flush_now) begin
      r_bank_reg  <= 1'b0;
      r_idx_reg   <= '0;
      rd_pend_reg <= 1'b0;
      rd_last_reg <= 1'b0;
    end else begin
      rd_pend_reg <= rd_issue;
      rd_last_reg <= rd_issue && rd_wrap;
      if (rd_issue) begin
        if (rd_wrap) begin
          r_idx_reg  <= '0;
          r_bank_reg <= ~r_bank_reg;
        end else begin
          r_idx_reg <= r_idx_reg + 1'b1;
        end
      end
    end
  end

  // Per-bank full flags; set by the final write, cleared by the final read.
  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    logic full_reg;
    logic set_hit;
    logic clr_hit;
    assign set_hit = wr_fire && wr_wrap && (w_bank_reg == 1'(gi));
    assign clr_hit = rd_issue && rd_wrap && (r_bank_reg == 1'(gi));
    assign bank_full_vec[gi] = full_reg;

    // A bank is never set and cleared in the same cycle, so priority is moot.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        full_reg <= 1'b0;
      end else if (flush_now) begin
        full_reg <= 1'b0;
      end else if (set_hit) begin
        full_reg <= 1'b1;
      end else if (clr_hit) begin
        full_reg <= 1'b0;
      end
    end
  end

  // Output FIFO pointers and occupancy; the push is the read issued last cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_wr_ptr_reg <= 1'b0;
      fifo_rd_ptr_reg <= 1'b0;
      fifo_cnt_reg    <= 2'd0;
    end else if (flush_now) begin
      fifo_wr_ptr_reg <= 1'b0;
      fifo_rd_ptr_reg <= 1'b0;
      fifo_cnt_reg    <= 2'd0;
    end else begin
      if (rd_pend_reg) fifo_wr_ptr_reg <= ~fifo_wr_ptr_reg;
      if (pop)         fifo_rd_ptr_reg <= ~fifo_rd_ptr_reg;
      fifo_cnt_reg <= fifo_cnt_reg + 2'(rd_pend_reg) - 2'(pop);
    end
  end

  // FIFO storage slots.
  for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
    logic [DATA_WIDTH-1:0] slot_data_reg;
    logic                  slot_last_reg;
    assign fifo_data[gi] = slot_data_reg;
    assign fifo_last[gi] = slot_last_reg;

    // Capture the returning buffer word when this slot is the push target.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        slot_data_reg <= '0;
        slot_last_reg <= 1'b0;
      end else if (rd_pend_reg && (fifo_wr_ptr_reg == 1'(gi))) begin
        slot_data_reg <= buf_data_out;
        slot_last_reg <= rd_last_reg;
      end
    end
  end

endmodule

// File: tb/tb_pe_pingpong_ctrl.sv
// tb_pe_pingpong_ctrl: self-checking bench for pe_pingpong_ctrl.
// A word-count model (words written, reads issued, words popped) predicts
// every handshake, address, flag and output word cycle by cycle.
`timescale 1ns/1ps

module tb_pe_pingpong_ctrl;

  localparam int N     = 4;
  localparam int DW    = 16;
  localparam int DEPTH = 2 * N;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          buf_write_en;
  logic [AW-1:0] buf_write_addr;
  logic [DW-1:0] buf_data_in;
  logic          buf_read_en;
  logic [AW-1:0] buf_read_addr;
  logic [DW-1:0] buf_data_out;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic [1:0]    bank_full;
  logic          flush_sig;
  int            ready_mode;

  always #5 clk = ~clk;

  pe_pingpong_ctrl #(.DATA_NUM(N), .DATA_WIDTH(DW)) dut (
    .clk(clk),
    .rst_n(rst_n),
`ifdef PE_PINGPONG_FLUSH_EN
    .flush(flush_sig),
`endif
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .buf_write_en(buf_write_en),
    .buf_write_addr(buf_write_addr),
    .buf_data_in(buf_data_in),
    .buf_read_en(buf_read_en),
    .buf_read_addr(buf_read_addr),
    .buf_data_out(buf_data_out),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_last(out_last),
    .bank_full(bank_full)
  );

  // Operand buffer with one-cycle registered read.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (buf_read_en)  buf_data_out <= mem[buf_read_addr];
    if (buf_write_en) mem[buf_write_addr] <= buf_data_in;
  end

  // PE-side ready: 0 = held low, 1 = held high, 2 = random 50%.
  always @(posedge clk) begin
    #1;
    out_ready = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : (ready_mode == 1);
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Reference model: counts of words written, reads issued, words popped.
  int            w_cnt = 0;
  int            r_cnt = 0;
  int            r_lag = 0;   // reads issued up to two cycles ago (data has landed)
  int            p_cnt = 0;
  logic [DW-1:0] exp_words [0:1023];

  always @(negedge clk) begin : monitor
    int         full_banks;
    int         rd_bank;
    int         exp_ir;
    int         exp_ov;
    int         exp_pop;
    int         exp_re;
    logic [1:0] exp_bf;
    if (!rst_n) begin
      w_cnt = 0; r_cnt = 0; r_lag = 0; p_cnt = 0;
    end else begin
      full_banks = w_cnt / N - r_cnt / N;
      rd_bank    = (r_cnt / N) % 2;
      exp_bf     = (full_banks == 2) ? 2'b11 :
                   (full_banks == 1) ? (rd_bank == 1 ? 2'b10 : 2'b01) : 2'b00;
      exp_ir     = (full_banks < 2) && !flush_sig;
      exp_ov     = (r_lag - p_cnt) > 0;
      exp_pop    = exp_ov && out_ready;
      exp_re     = (r_cnt < (w_cnt / N) * N) && ((r_cnt - p_cnt - exp_pop) < 2) && !flush_sig;

      check_eq("bank_full", bank_full, exp_bf);
      check_eq("in_ready", in_ready, exp_ir);
      check_eq("out_valid", out_valid, exp_ov);
      check_eq("buf_read_en", buf_read_en, exp_re);
      check_eq("buf_write_en", buf_write_en, in_valid && (exp_ir != 0));
      check_eq("fifo_occ_le2", (r_cnt - p_cnt) <= 2, 1);
      if (buf_write_en) begin
        check_eq("wr_addr", buf_write_addr, w_cnt % DEPTH);
        check_eq("wr_data", buf_data_in, in_data);
      end
      if (buf_read_en) check_eq("rd_addr", buf_read_addr, r_cnt % DEPTH);
      if (out_valid) begin
        check_eq("out_data", out_data, exp_words[p_cnt]);
        check_eq("out_last", out_last, (p_cnt % N) == N - 1);
      end

      if (flush_sig) begin
        w_cnt = 0; r_cnt = 0; r_lag = 0; p_cnt = 0;
      end else begin
        if (in_valid && in_ready) begin
          exp_words[w_cnt] = in_data;
          w_cnt++;
        end
        r_lag = r_cnt;
        if (buf_read_en) r_cnt++;
        if (out_valid && out_ready) p_cnt++;
      end
    end
  end

  // Present one word and hold it until accepted; called at posedge+1.
  task automatic send_word(input logic [DW-1:0] v, output int stall);
    int waited;
    waited   = 0;
    in_valid = 1'b1;
    in_data  = v;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      if (waited > 500) begin
        check_eq("send_timeout", waited, 0);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    stall    = waited;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 500; i++) begin
      if (p_cnt == w_cnt) break;
      @(posedge clk);
      #1;
    end
    check_eq("drain", p_cnt, w_cnt);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_in_ready"}, in_ready, 1);
    check_eq({tag, "_wr_en"}, buf_write_en, 0);
    check_eq({tag, "_rd_en"}, buf_read_en, 0);
    check_eq({tag, "_out_valid"}, out_valid, 0);
    check_eq({tag, "_out_last"}, out_last, 0);
    check_eq({tag, "_out_data"}, out_data, 0);
    check_eq({tag, "_bank_full"}, bank_full, 0);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int st;
    int stall_total;
    int lat;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; ready_mode = 0; flush_sig = 1'b0;
    #1;
    check_reset_outputs("rst");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single bank: addresses 0..3, latency to first output, flag release.
    ready_mode = 1;
    for (int v = 1; v <= 4; v++) send_word(DW'(v), st);
    $display("t1: wrote 4 words, bank_full=%b", bank_full);
    check_eq("t1_bank_full", bank_full, 2'b01);
    lat = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (out_valid) begin lat = k; break; end
    end
    check_eq("t1_latency", lat, 3);
    wait_drain();
    check_eq("t1_bank_full_clr", bank_full, 2'b00);

    // Continuous 12 words: no write stall after the first bank.
    do_reset();
    stall_total = 0;
    for (int v = 1; v <= 12; v++) begin
      send_word(DW'(v), st);
      if (v > 4) stall_total += st;
    end
    $display("t2: streamed 12 words, stalls=%0d", stall_total);
    check_eq("t2_no_stall", stall_total, 0);
    wait_drain();
    check_eq("t2_count", p_cnt, 12);

    // Backpressure: both banks fill, FIFO holds word 1.
    do_reset();
    ready_mode = 0;
    for (int v = 1; v <= 8; v++) send_word(DW'(v), st);
    repeat (4) @(negedge clk);
    $display("t3: held out_ready=0, in_ready=%b out_data=%0d", in_ready, out_data);
    check_eq("t3_in_ready", in_ready, 0);
    check_eq("t3_out_valid", out_valid, 1);
    check_eq("t3_out_data", out_data, 1);
    check_eq("t3_bank_full", bank_full, 2'b11);
    @(posedge clk);
    #1;
    ready_mode = 1;
    for (int v = 9; v <= 12; v++) send_word(DW'(v), st);
    wait_drain();
    check_eq("t3_count", p_cnt, 12);

    // Random PE backpressure and input gaps over 64 words.
    do_reset();
    ready_mode = 2;
    for (int i = 0; i < 64; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      send_word(DW'($urandom), st);
    end
    ready_mode = 1;
    wait_drain();
    $display("t4: random run, popped %0d words", p_cnt);
    check_eq("t4_count", p_cnt, 64);

    // Asynchronous reset after word 2 of bank 1.
    do_reset();
    ready_mode = 0;
    for (int v = 1; v <= 6; v++) send_word(DW'(v), st);
    rst_n = 1'b0;
    #1;
    $display("t5: reset asserted mid-bank, bank_full=%b out_valid=%b", bank_full, out_valid);
    check_reset_outputs("t5");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    ready_mode = 1;
    in_valid = 1'b1;
    in_data  = DW'(1);
    #1;
    check_eq("t5_first_addr", buf_write_addr, 0);
    for (int v = 1; v <= 4; v++) send_word(DW'(v), st);
    wait_drain();

`ifdef PE_PINGPONG_FLUSH_EN
    // Flush after a partial bank, then after a full bank plus two words.
    for (int rep = 0; rep < 2; rep++) begin
      do_reset();
      ready_mode = 0;
      for (int v = 1; v <= (rep == 0 ? 3 : 6); v++) send_word(DW'(v), st);
      flush_sig = 1'b1;
      @(posedge clk);
      #1;
      flush_sig = 1'b0;
      $display("t6: flush after %0d words, bank_full=%b", rep == 0 ? 3 : 6, bank_full);
      check_eq("t6_bank_full", bank_full, 2'b00);
      in_valid = 1'b1;
      in_data  = DW'(40);
      #1;
      check_eq("t6_first_addr", buf_write_addr, 0);
      ready_mode = 1;
      for (int v = 40; v < 44; v++) send_word(DW'(v), st);
      wait_drain();
      check_eq("t6_count", p_cnt, 4);
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
